// File: rtl/mem_arbiter.sv
// Two-port round-robin memory arbiter: grants one request at a time, issues a single
// memory strobe, waits LAT cycles for read data, then pulses the owner's ack.
module mem_arbiter #(
  parameter int unsigned LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        we0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        owner
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  localparam logic [1:0] CNT_INIT = 2'(LAT - 1);

  state_t     r_state;
  logic [1:0] r_cnt;
  logic       r_last_grant;
  logic       w_grant1;

  // Port 1 wins when alone, or under contention when port 0 was granted last.
  assign w_grant1 = req1 && (!req0 || !r_last_grant);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_last_grant <= 1'b1;
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      rdata        <= '0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      busy         <= 1'b0;
      owner        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          ack0 <= 1'b0;
          ack1 <= 1'b0;
          if (req0 || req1) begin
            owner        <= w_grant1;
            r_last_grant <= w_grant1;
            mem_we       <= w_grant1 ? we1 : we0;
            mem_addr     <= w_grant1 ? addr1 : addr0;
            mem_wdata    <= w_grant1 ? wdata1 : wdata0;
            mem_en       <= 1'b1;
            busy         <= 1'b1;
            r_state      <= ISSUE;
          end
        end
        ISSUE: begin
          mem_en  <= 1'b0;
          r_cnt   <= CNT_INIT;
          r_state <= WAIT;
        end
        WAIT: begin
          if (r_cnt == 2'd0) begin
            if (!mem_we) rdata <= mem_rdata;
            ack0    <= ~owner;
            ack1    <= owner;
            r_state <= ACK;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        ACK: begin
          ack0    <= 1'b0;
          ack1    <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a LAT=1 and a LAT=4 instance share port stimulus; each has a
// memory model that presents data only in the cycle LAT cycles after its strobe.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
  logic [31:0] mem_word = '0;

  logic        a_ack0, a_ack1, a_mem_en, a_mem_we, a_busy, a_owner;
  logic [31:0] a_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic        b_ack0, b_ack1, b_mem_en, b_mem_we, b_busy, b_owner;
  logic [31:0] b_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic        pa;
  logic [3:0]  pb;

  typedef struct {
    logic        port;
    logic [31:0] rdata;
  } exp_t;
  exp_t q[$];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.LAT(1)) u_dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack0(a_ack0), .ack1(a_ack1), .rdata(a_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata),
    .busy(a_busy), .owner(a_owner)
  );

  mem_arbiter #(.LAT(4)) u_dut4 (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack0(b_ack0), .ack1(b_ack1), .rdata(b_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
    .busy(b_busy), .owner(b_owner)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pa <= 1'b0;
      pb <= '0;
    end else begin
      pa <= a_mem_en;
      pb <= {pb[2:0], b_mem_en};
    end
  end

  assign a_mem_rdata = pa    ? (mem_word ^ a_mem_addr) : 32'hBAD0_BAD0;
  assign b_mem_rdata = pb[3] ? (mem_word ^ b_mem_addr) : 32'hBAD0_BAD0;

  task automatic reset_dut();
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h44;
    q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({a_ack0, a_ack1, a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata, a_rdata, a_busy, a_owner} !== '0) begin
      n_bad++;
      $display("FAIL reset_a: ack0=%b ack1=%b en=%b we=%b addr=%h wd=%h rd=%h busy=%b owner=%b required all 0",
               a_ack0, a_ack1, a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata, a_rdata, a_busy, a_owner);
    end
    n_cmp++;
    if ({b_ack0, b_ack1, b_mem_en, b_mem_we, b_mem_addr, b_mem_wdata, b_rdata, b_busy, b_owner} !== '0) begin
      n_bad++;
      $display("FAIL reset_b: en=%b busy=%b addr=%h rd=%h required all 0", b_mem_en, b_busy, b_mem_addr, b_rdata);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({a_busy, a_mem_en} !== 2'b00) begin
      n_bad++;
      $display("FAIL grant_before_edge: busy,en=%b required 00", {a_busy, a_mem_en});
    end
    @(posedge clk);
    #1 req0 = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({a_busy, a_mem_en, a_owner, a_mem_addr} !== {1'b1, 1'b1, 1'b0, 32'h44}) begin
      n_bad++;
      $display("FAIL first_grant: busy=%b en=%b owner=%b addr=%h required 1 1 0 00000044",
               a_busy, a_mem_en, a_owner, a_mem_addr);
    end
  endtask

  task automatic test_read_lat1();
    exp_t e;
    int   got = 0;
    int   en_cnt = 0;
    logic drop = 1'b0;
    reset_dut();
    mem_word = 32'hDEADBEEF ^ 32'h10;
    we0 = 1'b0; addr0 = 32'h10; req0 = 1'b1;
    q.push_back('{1'b0, 32'hDEADBEEF});
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (drop) begin req0 = 1'b0; drop = 1'b0; end
      @(negedge clk);
      if (k == 1) begin
        n_cmp++;
        if ({a_mem_en, a_busy, a_owner, a_mem_we, a_mem_addr} !== {1'b1, 1'b1, 1'b0, 1'b0, 32'h10}) begin
          n_bad++;
          $display("FAIL rd1_issue: en=%b busy=%b owner=%b we=%b addr=%h required 1 1 0 0 00000010",
                   a_mem_en, a_busy, a_owner, a_mem_we, a_mem_addr);
        end
      end
      if (a_mem_en) en_cnt++;
      n_cmp++;
      if (a_ack1 !== 1'b0) begin
        n_bad++;
        $display("FAIL rd1_ack1_quiet: cycle %0d ack1=%b required 0", k, a_ack1);
      end
      if (a_ack0 || a_ack1) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL rd1_extra_ack: cycle %0d ack with empty scoreboard", k);
        end else begin
          e = q.pop_front();
          if (a_rdata !== e.rdata || k != 3) begin
            n_bad++;
            $display("FAIL rd1_ack: cycle %0d rdata=%h required cycle 3 rdata=%h", k, a_rdata, e.rdata);
          end
        end
        got++;
        drop = 1'b1;
      end
    end
    n_cmp++;
    if (got != 1 || en_cnt != 1) begin
      n_bad++;
      $display("FAIL rd1_counts: acks=%0d mem_en cycles=%0d required 1 and 1", got, en_cnt);
    end
  endtask

  task automatic test_contention();
    exp_t e;
    int   got = 0;
    int   ack_k[2] = '{0, 0};
    logic drop0 = 1'b0, drop1 = 1'b0;
    reset_dut();
    mem_word = 32'h0F0F_5A5A;
    we0 = 1'b0; addr0 = 32'h100; we1 = 1'b0; addr1 = 32'h200;
    req0 = 1'b1; req1 = 1'b1;
    q.push_back('{1'b0, 32'h0F0F_5A5A ^ 32'h100});
    q.push_back('{1'b1, 32'h0F0F_5A5A ^ 32'h200});
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (drop0) begin req0 = 1'b0; drop0 = 1'b0; end
      if (drop1) begin req1 = 1'b0; drop1 = 1'b0; end
      @(negedge clk);
      if (a_ack0 || a_ack1) begin
        n_cmp++;
        if (q.size() == 0 || got >= 2) begin
          n_bad++;
          $display("FAIL cont_extra_ack: cycle %0d unexpected ack", k);
        end else begin
          e = q.pop_front();
          ack_k[got] = k;
          if ({a_ack0, a_ack1} !== {~e.port, e.port} || a_owner !== e.port || a_rdata !== e.rdata) begin
            n_bad++;
            $display("FAIL cont_ack%0d: ack0=%b ack1=%b owner=%b rdata=%h required port %0d rdata=%h",
                     got, a_ack0, a_ack1, a_owner, a_rdata, e.port, e.rdata);
          end
        end
        if (a_ack1) drop1 = 1'b1; else drop0 = 1'b1;
        got++;
      end
    end
    n_cmp++;
    if (got != 2 || ack_k[0] != 3 || ack_k[1] != 7) begin
      n_bad++;
      $display("FAIL cont_timing: acks=%0d at cycles %0d,%0d required 2 at 3,7", got, ack_k[0], ack_k[1]);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   got = 0;
    int   en_cnt = 0;
    logic drop = 1'b0;
    reset_dut();
    mem_word = 32'h1234_0000;
    we0 = 1'b0; addr0 = 32'h300; we1 = 1'b0; addr1 = 32'h304;
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 4; i++)
      q.push_back('{i[0], 32'h1234_0000 ^ (i[0] ? 32'h304 : 32'h300)});
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk); #1;
      if (drop) begin req0 = 1'b0; req1 = 1'b0; drop = 1'b0; end
      @(negedge clk);
      if (a_mem_en) en_cnt++;
      n_cmp++;
      if (a_ack0 && a_ack1) begin
        n_bad++;
        $display("FAIL b2b_both_ack: cycle %0d both acks high", k);
      end
      if (a_ack0 || a_ack1) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL b2b_extra_ack: cycle %0d unexpected ack", k);
        end else begin
          e = q.pop_front();
          if (a_ack1 !== e.port || a_rdata !== e.rdata || k != 3 + 4 * got) begin
            n_bad++;
            $display("FAIL b2b_ack%0d: cycle %0d port=%b rdata=%h required cycle %0d port=%b rdata=%h",
                     got, k, a_ack1, a_rdata, 3 + 4 * got, e.port, e.rdata);
          end
        end
        got++;
        if (got == 4) drop = 1'b1;
      end
    end
    n_cmp++;
    if (got != 4 || en_cnt != 4) begin
      n_bad++;
      $display("FAIL b2b_counts: acks=%0d mem_en cycles=%0d required 4 and 4", got, en_cnt);
    end
  endtask

  task automatic test_write();
    int   got = 0;
    logic drop = 1'b0;
    reset_dut();
    mem_word = 32'hCAFE_0000;
    we1 = 1'b1; addr1 = 32'h20; wdata1 = 32'h12345678; req1 = 1'b1;
    q.push_back('{1'b1, 32'h0});
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin addr1 = 32'hFFFF_0000; wdata1 = 32'h0; we1 = 1'b0; end
      if (drop) begin req1 = 1'b0; drop = 1'b0; end
      @(negedge clk);
      if (k <= 3) begin
        n_cmp++;
        if ({a_mem_we, a_mem_addr, a_mem_wdata} !== {1'b1, 32'h20, 32'h12345678}) begin
          n_bad++;
          $display("FAIL wr_hold: cycle %0d we=%b addr=%h wdata=%h required 1 00000020 12345678",
                   k, a_mem_we, a_mem_addr, a_mem_wdata);
        end
      end
      if (a_ack0 || a_ack1) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL wr_extra_ack: cycle %0d unexpected ack", k);
        end else if ({a_ack0, a_ack1} !== 2'b01 || a_rdata !== q[0].rdata || k != 3) begin
          n_bad++;
          $display("FAIL wr_ack: cycle %0d ack0=%b ack1=%b rdata=%h required cycle 3 ack1 rdata=%h",
                   k, a_ack0, a_ack1, a_rdata, q[0].rdata);
        end
        if (q.size() != 0) void'(q.pop_front());
        got++;
        drop = 1'b1;
      end
    end
    n_cmp++;
    if (got != 1 || a_rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL wr_end: acks=%0d rdata=%h required 1 and 00000000", got, a_rdata);
    end
  endtask

  task automatic test_lat4();
    exp_t e;
    int   got = 0;
    int   en_cnt = 0;
    logic drop = 1'b0;
    reset_dut();
    mem_word = 32'h7777_0000;
    we0 = 1'b0; addr0 = 32'h40; req0 = 1'b1;
    q.push_back('{1'b0, 32'h7777_0040});
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
      if (drop) begin req0 = 1'b0; drop = 1'b0; end
      @(negedge clk);
      if (b_mem_en) en_cnt++;
      if (k <= 6) begin
        n_cmp++;
        if ({b_busy, b_mem_en} !== {1'b1, k == 1}) begin
          n_bad++;
          $display("FAIL lat4_phase: cycle %0d busy=%b en=%b required busy 1 en %0d", k, b_busy, b_mem_en, k == 1);
        end
      end
      if (b_ack0 || b_ack1) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL lat4_extra_ack: cycle %0d unexpected ack", k);
        end else begin
          e = q.pop_front();
          if ({b_ack0, b_ack1} !== 2'b10 || b_rdata !== e.rdata || k != 6) begin
            n_bad++;
            $display("FAIL lat4_ack: cycle %0d ack0=%b ack1=%b rdata=%h required cycle 6 ack0 rdata=%h",
                     k, b_ack0, b_ack1, b_rdata, e.rdata);
          end
        end
        got++;
        drop = 1'b1;
      end
    end
    n_cmp++;
    if (got != 1 || en_cnt != 1) begin
      n_bad++;
      $display("FAIL lat4_counts: acks=%0d mem_en cycles=%0d required 1 and 1", got, en_cnt);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   got = 0;
    int   en_cnt = 0;
    logic drop = 1'b0;
    reset_dut();
    mem_word = 32'h5555_0000;
    we0 = 1'b0; addr0 = 32'h80; req0 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({b_busy, b_mem_en} !== 2'b10) begin
      n_bad++;
      $display("FAIL rstmid_in_wait: busy=%b en=%b required 1 0", b_busy, b_mem_en);
    end
    #1 reset = 1'b1;
    req0 = 1'b0;
    #1;
    n_cmp++;
    if ({b_ack0, b_ack1, b_mem_en, b_mem_we, b_mem_addr, b_mem_wdata, b_rdata, b_busy, b_owner} !== '0) begin
      n_bad++;
      $display("FAIL rstmid_clear: ack0=%b ack1=%b en=%b addr=%h busy=%b required all 0",
               b_ack0, b_ack1, b_mem_en, b_mem_addr, b_busy);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({b_ack0, b_ack1, b_mem_en, b_busy} !== 4'b0000) begin
        n_bad++;
        $display("FAIL rstmid_quiet: cycle %0d ack0=%b ack1=%b en=%b busy=%b required 0000",
                 k, b_ack0, b_ack1, b_mem_en, b_busy);
      end
    end
    @(posedge clk); #1;
    we1 = 1'b0; addr1 = 32'h90; req1 = 1'b1;
    q.push_back('{1'b1, 32'h5555_0090});
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (drop) begin req1 = 1'b0; drop = 1'b0; end
      @(negedge clk);
      if (b_mem_en) en_cnt++;
      if (b_ack0 || b_ack1) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL rstmid_extra_ack: cycle %0d unexpected ack", k);
        end else begin
          e = q.pop_front();
          if ({b_ack0, b_ack1} !== 2'b01 || b_rdata !== e.rdata || k != 6) begin
            n_bad++;
            $display("FAIL rstmid_next: cycle %0d ack0=%b ack1=%b rdata=%h required cycle 6 ack1 rdata=%h",
                     k, b_ack0, b_ack1, b_rdata, e.rdata);
          end
        end
        got++;
        drop = 1'b1;
      end
    end
    n_cmp++;
    if (got != 1 || en_cnt != 1) begin
      n_bad++;
      $display("FAIL rstmid_counts: acks=%0d mem_en cycles=%0d required 1 and 1", got, en_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_read_lat1();
    test_contention();
    test_back_to_back();
    test_write();
    test_lat4();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
